eu_tx_buf: RTL and testbench

Transmit-side result buffer of an execution unit: accepts completed ALU results (destination address plus data), queues them in order, and presents them one at a time on the interconnect transmit channel that feeds the receiving unit's cache. Each packet is held on the channel until the receiver signals `success`, and only then retired. The block absorbs receiver back-pressure so the ALU stalls only when the queue is full. A watchdog flags a receiver that never accepts.

---
 rtl/pkg_dtypes.sv | 16 +
 rtl/counter_JK.sv | 33 +++
 rtl/fifo_mem_sp.sv | 26 ++
 rtl/eu_tx_buf.sv | 103 ++++++++++
 tb/tb_eu_tx_buf.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pkg_dtypes.sv
// rtl/pkg_dtypes.sv - shared datatypes for the execution unit and interconnect
// Holds the cache address type, result data width and the transmit channel record.
package pkg_dtypes;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 8;

    typedef logic [ADDR_WIDTH-1:0] type_exec_unit_addr;

    typedef struct packed {
        logic                  valid;
        type_exec_unit_addr    addr;
        logic [DATA_WIDTH-1:0] data;
    } type_icon_tx_channel;

endpackage

// File: rtl/counter_JK.sv
// rtl/counter_JK.sv - shared up/down occupancy counter
// Ports: clk, reset_n (async active-low), trig (step this cycle),
//        inc_or_dec (1 = up, 0 = down), count_o (current value).
module counter_JK #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             trig,
    input  logic             inc_or_dec,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (trig) begin
            count_d = inc_or_dec ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fifo_mem_sp.sv
// rtl/fifo_mem_sp.sv - FIFO storage array, one write port, asynchronous read
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i/rdata_o (combinational read).
module fifo_mem_sp #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    // Contents are deliberately not reset: occupancy alone decides validity.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/eu_tx_buf.sv
// rtl/eu_tx_buf.sv - execution unit transmit result buffer with receiver watchdog
// Queues ALU results in order and holds each on the transmit channel until the
// receiver returns success.
// Ports: clk, reset_n (async active-low);
//        alu_res_valid/alu_res_addr/alu_res_data in, alu_res_ready out;
//        out_pkt {valid,addr,data} out, success in;
//        count_o occupancy, timeout_o sticky watchdog flag.
module eu_tx_buf
    import pkg_dtypes::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    alu_res_valid,
    input  type_exec_unit_addr      alu_res_addr,
    input  logic [DATA_WIDTH-1:0]   alu_res_data,
    output logic                    alu_res_ready,
    output type_icon_tx_channel     out_pkt,
    input  logic                    success,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    timeout_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT_CYCLES);

    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] count;
    logic [EW-1:0] rd_entry;
    logic          pkt_valid, push, pop;

    // Ready looks only at the current count, so a pop in a full cycle does not
    // open a slot until the following cycle.
    assign alu_res_ready = (count != FULL_CNT);
    assign pkt_valid     = (count != '0);
    assign push          = alu_res_valid & alu_res_ready;
    assign pop           = pkt_valid & success;

    counter_JK #(
        .WIDTH      (CW)
    ) u_count (
        .clk        (clk),
        .reset_n    (reset_n),
        .trig       (push ^ pop),
        .inc_or_dec (push),
        .count_o    (count)
    );

    fifo_mem_sp #(
        .DEPTH   (DEPTH),
        .WIDTH   (EW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wp_q),
        .wdata_i ({alu_res_addr, alu_res_data}),
        .raddr_i (rp_q),
        .rdata_o (rd_entry)
    );

    always_comb begin
        wp_d      = push ? wp_q + AW'(1) : wp_q;
        rp_d      = pop  ? rp_q + AW'(1) : rp_q;
        stall_d   = stall_q;
        timeout_d = timeout_q;
        if (!pkt_valid || success) begin
            stall_d = '0;
        end else if (stall_q != STALL_LIM) begin
            stall_d = stall_q + SW'(1);
        end
        // Flag goes up on the same edge the counter reaches the limit.
        if (stall_d == STALL_LIM) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q      <= '0;
            rp_q      <= '0;
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign out_pkt   = {pkt_valid, rd_entry};
    assign count_o   = count;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_eu_tx_buf.sv
// tb/tb_eu_tx_buf.sv - self-checking bench for eu_tx_buf
module tb_eu_tx_buf;
    import pkg_dtypes::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  alu_res_valid = 1'b0;
    type_exec_unit_addr    alu_res_addr = '0;
    logic [DATA_WIDTH-1:0] alu_res_data = '0;
    logic                  alu_res_ready;
    type_icon_tx_channel   out_pkt;
    logic                  success = 1'b0;
    logic [2:0]            count_o;
    logic                  timeout_o;

    eu_tx_buf #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .alu_res_valid (alu_res_valid),
        .alu_res_addr  (alu_res_addr),
        .alu_res_data  (alu_res_data),
        .alu_res_ready (alu_res_ready),
        .out_pkt       (out_pkt),
        .success       (success),
        .count_o       (count_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a plain queue of {addr,data} plus a stall tally.
    logic [15:0] mq[$];
    int          m_stall = 0;
    bit          m_tmo = 1'b0;

    typedef struct {
        bit         rst;
        bit         v;
        logic [7:0] a;
        logic [7:0] d;
        bit         s;
        bit         e_ready;
        bit         e_valid;
        logic [7:0] e_addr;
        logic [7:0] e_data;
        int         e_cnt;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("m_ready", 32'(alu_res_ready), 32'(mq.size() < DEPTH));
        chk("m_valid", 32'(out_pkt.valid), 32'(mq.size() > 0));
        chk("m_count", 32'(count_o), 32'(mq.size()));
        chk("m_timeout", 32'(timeout_o), 32'(m_tmo));
        if (mq.size() > 0) begin
            chk("m_pkt", {16'h0, out_pkt.addr, out_pkt.data}, {16'h0, mq[0]});
        end
    endtask

    task automatic model_step(input bit v, input logic [7:0] a, input logic [7:0] d, input bit s);
        bit nonempty;
        bit do_push;
        nonempty = (mq.size() > 0);
        do_push  = v && (mq.size() < DEPTH);
        if (nonempty && s) void'(mq.pop_front());
        if (do_push) mq.push_back({a, d});
        if (nonempty && !s) m_stall = (m_stall < TMO) ? m_stall + 1 : TMO;
        else m_stall = 0;
        if (m_stall == TMO) m_tmo = 1'b1;
    endtask

    task automatic drive(input bit v, input logic [7:0] a, input logic [7:0] d, input bit s);
        alu_res_valid = v;
        alu_res_addr  = a;
        alu_res_data  = d;
        success       = s;
    endtask

    task automatic cycle(input bit v, input logic [7:0] a, input logic [7:0] d, input bit s);
        drive(v, a, d, s);
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_step(v, a, d, s);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h0, 8'h0, 1'b0);
        reset_n = 1'b0;
        mq.delete();
        m_stall = 0;
        m_tmo   = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] popped[$];
        logic [7:0] base;
        int         guard;

        // Single packet, then fill / back-pressure with DEPTH=4.
        tbl[0]  = '{1, 1, 8'h05, 8'hA5, 0, 1, 0, 8'h00, 8'h00, 0};
        tbl[1]  = '{0, 0, 8'h00, 8'h00, 0, 1, 1, 8'h05, 8'hA5, 1};
        tbl[2]  = '{0, 0, 8'h00, 8'h00, 0, 1, 1, 8'h05, 8'hA5, 1};
        tbl[3]  = '{0, 0, 8'h00, 8'h00, 0, 1, 1, 8'h05, 8'hA5, 1};
        tbl[4]  = '{0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h05, 8'hA5, 1};
        tbl[5]  = '{0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00, 0};
        tbl[6]  = '{1, 1, 8'h10, 8'h10, 0, 1, 0, 8'h00, 8'h00, 0};
        tbl[7]  = '{0, 1, 8'h11, 8'h11, 0, 1, 1, 8'h10, 8'h10, 1};
        tbl[8]  = '{0, 1, 8'h12, 8'h12, 0, 1, 1, 8'h10, 8'h10, 2};
        tbl[9]  = '{0, 1, 8'h13, 8'h13, 0, 1, 1, 8'h10, 8'h10, 3};
        tbl[10] = '{0, 1, 8'h14, 8'h14, 0, 0, 1, 8'h10, 8'h10, 4};
        tbl[11] = '{0, 1, 8'h14, 8'h14, 1, 0, 1, 8'h10, 8'h10, 4};
        tbl[12] = '{0, 1, 8'h14, 8'h14, 1, 1, 1, 8'h11, 8'h11, 3};
        tbl[13] = '{0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h12, 8'h12, 3};
        tbl[14] = '{0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h13, 8'h13, 2};
        tbl[15] = '{0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h14, 8'h14, 1};
        tbl[16] = '{0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00, 0};

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].s);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), 32'(alu_res_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_valid", i), 32'(out_pkt.valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_count", i), 32'(count_o), 32'(tbl[i].e_cnt));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_addr", i), 32'(out_pkt.addr), 32'(tbl[i].e_addr));
                chk($sformatf("tbl%0d_data", i), 32'(out_pkt.data), 32'(tbl[i].e_data));
            end
            model_check();
            @(posedge clk);
            model_step(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].s);
            #1;
        end

        // Streaming with success tied high: one packet per cycle, in order.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(i < 10, 8'(8'h40 + i), 8'(8'hC0 + i), 1'b1);
            @(negedge clk);
            model_check();
            chk("stream_ready", 32'(alu_res_ready), 32'd1);
            chk("stream_cnt_le1", 32'(count_o <= 3'd1), 32'd1);
            if (out_pkt.valid) popped.push_back(out_pkt.addr);
            @(posedge clk);
            model_step(i < 10, 8'(8'h40 + i), 8'(8'hC0 + i), 1'b1);
            #1;
        end
        chk("stream_npkts", 32'(popped.size()), 32'd10);
        for (int i = 0; i < popped.size(); i++) begin
            chk("stream_order", 32'(popped[i]), 32'(8'h40 + i));
        end

        // Wrap-around: three fill/drain rounds with irregular success gaps.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            base = 8'(8'h20 + 16 * r);
            for (int i = 0; i < 4; i++) cycle(1'b1, 8'(base + i), 8'(~(base + i)), 1'b0);
            guard = 0;
            while (mq.size() > 0 && guard < 40) begin
                cycle(1'b0, 8'h0, 8'h0, ((guard + r) % 3) != 0);
                guard++;
            end
            chk("wrap_drained", 32'(guard < 40), 32'd1);
            @(negedge clk);
            chk("wrap_count0", 32'(count_o), 32'd0);
            @(posedge clk);
            #1;
        end

        // Spurious success on an empty queue, then the watchdog.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h0, 8'h0, 1'b1);
        cycle(1'b1, 8'h77, 8'h99, 1'b0);
        for (int k = 1; k <= TMO + 2; k++) begin
            cycle(1'b0, 8'h0, 8'h0, 1'b0);
            chk($sformatf("wdog_k%0d", k), 32'(timeout_o), 32'(k >= TMO));
        end
        cycle(1'b0, 8'h0, 8'h0, 1'b1);
        cycle(1'b0, 8'h0, 8'h0, 1'b0);
        chk("wdog_sticky", 32'(timeout_o), 32'd1);
        chk("wdog_popped", 32'(count_o), 32'd0);

        // Asynchronous reset in the middle of a cycle with three queued packets.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h60 + i), 8'(8'h61 + i), 1'b0);
        for (int i = 0; i < TMO + 1; i++) cycle(1'b0, 8'h0, 8'h0, 1'b0);
        chk("ar_pre_timeout", 32'(timeout_o), 32'd1);
        chk("ar_pre_count", 32'(count_o), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_pkt.valid), 32'd0);
        chk("ar_count", 32'(count_o), 32'd0);
        chk("ar_timeout", 32'(timeout_o), 32'd0);
        chk("ar_ready", 32'(alu_res_ready), 32'd1);
        mq.delete();
        m_stall = 0;
        m_tmo   = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(1'b1, 8'h5A, 8'h3C, 1'b0);
        cycle(1'b0, 8'h0, 8'h0, 1'b1);

        // Randomised traffic against the queue model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit v;
            bit s;
            v = ($urandom % 3) != 0;
            s = (i % 100 < 20) ? 1'b0 : (($urandom % 4) != 0);
            cycle(v, 8'($urandom), 8'($urandom), s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
